// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: word width, state encoding
// and the bundle of control strobes decoded from the state.
package fetch_sequencer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T0_ADDR  = 3'd1,
    ST_T1_READ  = 3'd2,
    ST_T2_IR    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_REDIRECT = 3'd5,
    ST_HALTED   = 3'd6
  } fs_state_e;

  typedef struct packed {
    logic pc_enable;
    logic pc_inc;
    logic mar_en;
    logic mem_read;
    logic ir_en;
    logic exec_start;
    logic busy;
  } fs_ctrl_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch/execute sequencer with branch redirect, halt
// at instruction boundaries and a retired-instruction counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              halt_req,
  input  logic              mem_ready,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic              pc_enable,
  output logic              pc_inc,
  output logic [WORD_W-1:0] pc_din,
  output logic              mar_en,
  output logic              mem_read,
  output logic              ir_en,
  output logic              exec_start,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  fs_state_e         state_q, state_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  fs_ctrl_t          ctrl;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b0;
      target_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      target_q  <= target_d;
      retired_q <= retired_d;
    end
  end

  // halt_req is only looked at where an instruction ends, so a fetch in
  // flight always runs to completion.
  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    target_d  = target_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_T0_ADDR;
      ST_T0_ADDR: state_d = ST_T1_READ;
      ST_T1_READ: if (mem_ready) state_d = ST_T2_IR;
      ST_T2_IR: begin
        state_d = ST_EXEC;
        first_d = 1'b1;
      end
      ST_EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + CNT_W'(1);
          if (branch_taken) begin
            target_d = branch_target;
            state_d  = ST_REDIRECT;
          end else begin
            state_d = halt_req ? ST_HALTED : ST_T0_ADDR;
          end
        end
      end
      ST_REDIRECT: state_d = halt_req ? ST_HALTED : ST_T0_ADDR;
      ST_HALTED:   state_d = ST_HALTED;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    pc_din = '0;
    case (state_q)
      ST_T0_ADDR: begin
        ctrl.pc_enable = 1'b1;
        ctrl.pc_inc    = 1'b1;
        ctrl.mar_en    = 1'b1;
        ctrl.busy      = 1'b1;
      end
      ST_T1_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.busy     = 1'b1;
      end
      ST_T2_IR: begin
        ctrl.ir_en = 1'b1;
        ctrl.busy  = 1'b1;
      end
      ST_EXEC: begin
        ctrl.exec_start = first_q;
        ctrl.busy       = 1'b1;
      end
      ST_REDIRECT: begin
        ctrl.pc_enable = 1'b1;
        ctrl.busy      = 1'b1;
        pc_din         = target_q;
      end
      default: ctrl = '0;
    endcase
  end

  assign pc_enable  = ctrl.pc_enable;
  assign pc_inc     = ctrl.pc_inc;
  assign mar_en     = ctrl.mar_en;
  assign mem_read   = ctrl.mem_read;
  assign ir_en      = ctrl.ir_en;
  assign exec_start = ctrl.exec_start;
  assign busy       = ctrl.busy;
  assign retired    = retired_q;

endmodule
